// File: rtl/id_ex_stage_pkg.sv
//------------------------------------------------------------------------------
// Module   : id_ex_stage_pkg
// Brief    : ALU op codes, RV32I opcodes, operand-select codes and the decode
//            helper shared by the ID/EX stage.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package id_ex_stage_pkg;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_XOR  = 4'd2;
    localparam logic [3:0] ALU_SLL  = 4'd3;
    localparam logic [3:0] ALU_SRL  = 4'd4;
    localparam logic [3:0] ALU_SRA  = 4'd5;
    localparam logic [3:0] ALU_ADD  = 4'd6;
    localparam logic [3:0] ALU_SUB  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [1:0] ARG1_SEL_RS1  = 2'd0;
    localparam logic [1:0] ARG1_SEL_ZERO = 2'd1;
    localparam logic [1:0] ARG1_SEL_PC   = 2'd2;

    localparam logic [1:0] ARG2_SEL_RS2  = 2'd0;
    localparam logic [1:0] ARG2_SEL_IMM  = 2'd1;
    localparam logic [1:0] ARG2_SEL_FOUR = 2'd2;

    typedef struct packed {
        logic [3:0] alu_op;
        logic [1:0] arg1_sel;
        logic [1:0] arg2_sel;
        logic       reg_wen;
        logic       illegal;
    } dec_t;

    function automatic logic [3:0] alu_from_funct3(input logic [2:0] funct3,
                                                   input logic       alt);
        logic [3:0] op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic dec_t decode(input logic [6:0] opcode,
                                    input logic [2:0] funct3,
                                    input logic       funct7_b5,
                                    input logic       rd_nonzero);
        dec_t d;
        d.alu_op   = ALU_ADD;
        d.arg1_sel = ARG1_SEL_RS1;
        d.arg2_sel = ARG2_SEL_RS2;
        d.reg_wen  = 1'b0;
        d.illegal  = 1'b0;
        case (opcode)
            OPC_OP: begin
                d.alu_op  = alu_from_funct3(funct3, funct7_b5);
                d.reg_wen = rd_nonzero;
            end
            OPC_OP_IMM: begin
                // instr[30] is an immediate bit except on shift-right
                d.alu_op   = alu_from_funct3(funct3, funct7_b5 && (funct3 == 3'b101));
                d.arg2_sel = ARG2_SEL_IMM;
                d.reg_wen  = rd_nonzero;
            end
            OPC_LOAD: begin
                d.arg2_sel = ARG2_SEL_IMM;
                d.reg_wen  = rd_nonzero;
            end
            OPC_STORE: begin
                d.arg2_sel = ARG2_SEL_IMM;
            end
            OPC_BRANCH: begin
                case (funct3[2:1])
                    2'b10:   d.alu_op = ALU_SLT;
                    2'b11:   d.alu_op = ALU_SLTU;
                    default: d.alu_op = ALU_SUB;
                endcase
            end
            OPC_LUI: begin
                d.arg1_sel = ARG1_SEL_ZERO;
                d.arg2_sel = ARG2_SEL_IMM;
                d.reg_wen  = rd_nonzero;
            end
            OPC_AUIPC: begin
                d.arg1_sel = ARG1_SEL_PC;
                d.arg2_sel = ARG2_SEL_IMM;
                d.reg_wen  = rd_nonzero;
            end
            OPC_JAL, OPC_JALR: begin
                d.arg1_sel = ARG1_SEL_PC;
                d.arg2_sel = ARG2_SEL_FOUR;
                d.reg_wen  = rd_nonzero;
            end
            default: begin
                d.illegal = 1'b1;
            end
        endcase
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/id_ex_stage_fwd_mux.sv
//------------------------------------------------------------------------------
// Module   : fwd_mux
// Brief    : Single-operand forward select; EX/MEM beats MEM/WB beats held data.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fwd_mux #(
    parameter int WORD_SIZE  = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] i_rs,
    input  logic [WORD_SIZE-1:0]  i_held_data,
    input  logic                  i_exmem_wen,
    input  logic [REG_ADDR_W-1:0] i_exmem_rd,
    input  logic [WORD_SIZE-1:0]  i_exmem_result,
    input  logic                  i_memwb_wen,
    input  logic [REG_ADDR_W-1:0] i_memwb_rd,
    input  logic [WORD_SIZE-1:0]  i_memwb_result,
    output logic [WORD_SIZE-1:0]  o_data
);

    logic w_exmem_hit;
    logic w_memwb_hit;

    assign w_exmem_hit = i_exmem_wen && (i_exmem_rd == i_rs) && (i_rs != '0);
    assign w_memwb_hit = i_memwb_wen && (i_memwb_rd == i_rs) && (i_rs != '0);

    always_comb begin
        o_data = i_held_data;
        if (w_exmem_hit) begin
            o_data = i_exmem_result;
        end else if (w_memwb_hit) begin
            o_data = i_memwb_result;
        end
    end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
//------------------------------------------------------------------------------
// Module   : id_ex_stage
// Brief    : ID/EX pipeline register, ALU op decode and operand select.
//            Forwarding and stall refresh are built only with ALU_FWD_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module id_ex_stage #(
    parameter int WORD_SIZE  = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    output logic                  id_ready,
    input  logic [WORD_SIZE-1:0]  id_pc,
    input  logic [6:0]            id_opcode,
    input  logic [2:0]            id_funct3,
    input  logic                  id_funct7_b5,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [WORD_SIZE-1:0]  id_rs1_data,
    input  logic [WORD_SIZE-1:0]  id_rs2_data,
    input  logic [WORD_SIZE-1:0]  id_imm,
    input  logic                  flush,
    input  logic                  ex_ready,
    input  logic                  exmem_wen,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic [WORD_SIZE-1:0]  exmem_result,
    input  logic                  memwb_wen,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic [WORD_SIZE-1:0]  memwb_result,
    output logic                  ex_valid,
    output logic [3:0]            alu_op,
    output logic [WORD_SIZE-1:0]  arg1,
    output logic [WORD_SIZE-1:0]  arg2,
    output logic [WORD_SIZE-1:0]  ex_store_data,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_reg_wen,
    output logic [WORD_SIZE-1:0]  ex_pc,
    output logic                  ex_illegal
);

    import id_ex_stage_pkg::*;

    localparam logic [WORD_SIZE-1:0] c_link_offset = WORD_SIZE'(4);

    logic                  r_valid;
    logic [WORD_SIZE-1:0]  r_pc;
    logic [WORD_SIZE-1:0]  r_rs1_data;
    logic [WORD_SIZE-1:0]  r_rs2_data;
    logic [WORD_SIZE-1:0]  r_imm;
    logic [REG_ADDR_W-1:0] r_rs1;
    logic [REG_ADDR_W-1:0] r_rs2;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [3:0]            r_alu_op;
    logic [1:0]            r_arg1_sel;
    logic [1:0]            r_arg2_sel;
    logic                  r_reg_wen;
    logic                  r_illegal;

    logic                  w_capture;
    dec_t                  w_dec;
    logic                  w_exmem_wen;
    logic                  w_memwb_wen;
    logic                  w_refresh_rs1;
    logic                  w_refresh_rs2;
    logic [WORD_SIZE-1:0]  w_rs1_fwd;
    logic [WORD_SIZE-1:0]  w_rs2_fwd;
    logic [WORD_SIZE-1:0]  w_store_fwd;

    assign id_ready  = !r_valid || ex_ready;
    assign w_capture = id_valid && id_ready;
    assign w_dec     = decode(id_opcode, id_funct3, id_funct7_b5, id_rd != '0);

`ifdef ALU_FWD_EN
    logic w_stall;

    assign w_exmem_wen   = exmem_wen;
    assign w_memwb_wen   = memwb_wen;
    // A result retiring from MEM/WB while stalled would otherwise be lost
    assign w_stall       = r_valid && !ex_ready;
    assign w_refresh_rs1 = w_stall && memwb_wen && (memwb_rd == r_rs1) && (r_rs1 != '0);
    assign w_refresh_rs2 = w_stall && memwb_wen && (memwb_rd == r_rs2) && (r_rs2 != '0);
`else
    logic w_unused_fwd;

    assign w_exmem_wen   = 1'b0;
    assign w_memwb_wen   = 1'b0;
    assign w_refresh_rs1 = 1'b0;
    assign w_refresh_rs2 = 1'b0;
    assign w_unused_fwd  = exmem_wen ^ memwb_wen;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_alu_op   <= ALU_AND;
            r_arg1_sel <= ARG1_SEL_RS1;
            r_arg2_sel <= ARG2_SEL_RS2;
            r_reg_wen  <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_capture) begin
                r_valid <= 1'b1;
            end else if (ex_ready) begin
                r_valid <= 1'b0;
            end

            if (w_capture) begin
                r_pc       <= id_pc;
                r_rs1_data <= id_rs1_data;
                r_rs2_data <= id_rs2_data;
                r_imm      <= id_imm;
                r_rs1      <= id_rs1;
                r_rs2      <= id_rs2;
                r_rd       <= id_rd;
                r_alu_op   <= w_dec.alu_op;
                r_arg1_sel <= w_dec.arg1_sel;
                r_arg2_sel <= w_dec.arg2_sel;
                r_reg_wen  <= w_dec.reg_wen;
                r_illegal  <= w_dec.illegal;
            end else begin
                if (w_refresh_rs1) begin
                    r_rs1_data <= memwb_result;
                end
                if (w_refresh_rs2) begin
                    r_rs2_data <= memwb_result;
                end
            end
        end
    end

    fwd_mux #(.WORD_SIZE(WORD_SIZE), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
        .i_rs          (r_rs1),
        .i_held_data   (r_rs1_data),
        .i_exmem_wen   (w_exmem_wen),
        .i_exmem_rd    (exmem_rd),
        .i_exmem_result(exmem_result),
        .i_memwb_wen   (w_memwb_wen),
        .i_memwb_rd    (memwb_rd),
        .i_memwb_result(memwb_result),
        .o_data        (w_rs1_fwd)
    );

    fwd_mux #(.WORD_SIZE(WORD_SIZE), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
        .i_rs          (r_rs2),
        .i_held_data   (r_rs2_data),
        .i_exmem_wen   (w_exmem_wen),
        .i_exmem_rd    (exmem_rd),
        .i_exmem_result(exmem_result),
        .i_memwb_wen   (w_memwb_wen),
        .i_memwb_rd    (memwb_rd),
        .i_memwb_result(memwb_result),
        .o_data        (w_rs2_fwd)
    );

    fwd_mux #(.WORD_SIZE(WORD_SIZE), .REG_ADDR_W(REG_ADDR_W)) u_fwd_store (
        .i_rs          (r_rs2),
        .i_held_data   (r_rs2_data),
        .i_exmem_wen   (w_exmem_wen),
        .i_exmem_rd    (exmem_rd),
        .i_exmem_result(exmem_result),
        .i_memwb_wen   (w_memwb_wen),
        .i_memwb_rd    (memwb_rd),
        .i_memwb_result(memwb_result),
        .o_data        (w_store_fwd)
    );

    always_comb begin
        case (r_arg1_sel)
            ARG1_SEL_ZERO: arg1 = '0;
            ARG1_SEL_PC:   arg1 = r_pc;
            default:       arg1 = w_rs1_fwd;
        endcase
    end

    always_comb begin
        case (r_arg2_sel)
            ARG2_SEL_IMM:  arg2 = r_imm;
            ARG2_SEL_FOUR: arg2 = c_link_offset;
            default:       arg2 = w_rs2_fwd;
        endcase
    end

    assign ex_valid      = r_valid;
    assign alu_op        = r_alu_op;
    assign ex_store_data = w_store_fwd;
    assign ex_rd         = r_rd;
    assign ex_reg_wen    = r_reg_wen;
    assign ex_pc         = r_pc;
    assign ex_illegal    = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
//------------------------------------------------------------------------------
// Module   : tb_id_ex_stage
// Brief    : Directed self-checking bench for id_ex_stage; expected forwarding
//            results follow whether ALU_FWD_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_id_ex_stage;

    localparam int WORD_SIZE  = 32;
    localparam int REG_ADDR_W = 5;
`ifdef ALU_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic                  clk;
    logic                  rst;
    logic                  id_valid;
    logic                  id_ready;
    logic [WORD_SIZE-1:0]  id_pc;
    logic [6:0]            id_opcode;
    logic [2:0]            id_funct3;
    logic                  id_funct7_b5;
    logic [REG_ADDR_W-1:0] id_rs1, id_rs2, id_rd;
    logic [WORD_SIZE-1:0]  id_rs1_data, id_rs2_data, id_imm;
    logic                  flush;
    logic                  ex_ready;
    logic                  exmem_wen;
    logic [REG_ADDR_W-1:0] exmem_rd;
    logic [WORD_SIZE-1:0]  exmem_result;
    logic                  memwb_wen;
    logic [REG_ADDR_W-1:0] memwb_rd;
    logic [WORD_SIZE-1:0]  memwb_result;
    logic                  ex_valid;
    logic [3:0]            alu_op;
    logic [WORD_SIZE-1:0]  arg1, arg2, ex_store_data, ex_pc;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_reg_wen;
    logic                  ex_illegal;

    int n_cmp = 0;
    int n_err = 0;

    id_ex_stage #(.WORD_SIZE(WORD_SIZE), .REG_ADDR_W(REG_ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .id_pc        (id_pc),
        .id_opcode    (id_opcode),
        .id_funct3    (id_funct3),
        .id_funct7_b5 (id_funct7_b5),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_rs1_data  (id_rs1_data),
        .id_rs2_data  (id_rs2_data),
        .id_imm       (id_imm),
        .flush        (flush),
        .ex_ready     (ex_ready),
        .exmem_wen    (exmem_wen),
        .exmem_rd     (exmem_rd),
        .exmem_result (exmem_result),
        .memwb_wen    (memwb_wen),
        .memwb_rd     (memwb_rd),
        .memwb_result (memwb_result),
        .ex_valid     (ex_valid),
        .alu_op       (alu_op),
        .arg1         (arg1),
        .arg2         (arg2),
        .ex_store_data(ex_store_data),
        .ex_rd        (ex_rd),
        .ex_reg_wen   (ex_reg_wen),
        .ex_pc        (ex_pc),
        .ex_illegal   (ex_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_idle();
        id_valid = 1'b0; id_pc = '0; id_opcode = '0; id_funct3 = '0; id_funct7_b5 = 1'b0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
        flush = 1'b0; ex_ready = 1'b1;
        exmem_wen = 1'b0; exmem_rd = '0; exmem_result = '0;
        memwb_wen = 1'b0; memwb_rd = '0; memwb_result = '0;
    endtask

    task automatic load(input logic [31:0] pc, input logic [6:0] opc, input logic [2:0] f3,
                        input logic b5, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm);
        id_valid = 1'b1; id_pc = pc; id_opcode = opc; id_funct3 = f3; id_funct7_b5 = b5;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_idle();
        repeat (3) @(negedge clk);
        n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", ex_valid); end
        n_cmp++; if (alu_op !== 4'd0) begin n_err++; $display("FAIL reset_alu_op: got %0d want 0", alu_op); end
        n_cmp++; if (arg1 !== 32'd0 || arg2 !== 32'd0) begin n_err++; $display("FAIL reset_args: got %h/%h want 0/0", arg1, arg2); end
        n_cmp++; if (id_ready !== 1'b1) begin n_err++; $display("FAIL reset_id_ready: got %b want 1", id_ready); end
        rst = 1'b0;
    endtask

    task automatic test_alu_decode();
        // sub x3,x1,x2
        load(32'h0, 7'b0110011, 3'b000, 1'b1, 5'd1, 5'd2, 5'd3, 32'd10, 32'd3, 32'd0);
        @(negedge clk);
        id_valid = 1'b0;
        n_cmp++; if (ex_valid !== 1'b1) begin n_err++; $display("FAIL sub_valid: got %b want 1", ex_valid); end
        n_cmp++; if (alu_op !== 4'd7) begin n_err++; $display("FAIL sub_alu_op: got %0d want 7", alu_op); end
        n_cmp++; if (arg1 !== 32'd10 || arg2 !== 32'd3) begin n_err++; $display("FAIL sub_args: got %0d/%0d want 10/3", arg1, arg2); end
        n_cmp++; if (ex_rd !== 5'd3 || ex_reg_wen !== 1'b1) begin n_err++; $display("FAIL sub_rd: got %0d/%b want 3/1", ex_rd, ex_reg_wen); end
        @(negedge clk);
        n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid: got %b want 0", ex_valid); end
        // srai x5,x6,4
        load(32'h4, 7'b0010011, 3'b101, 1'b1, 5'd6, 5'd4, 5'd5, 32'h80, 32'd0, 32'h404);
        @(negedge clk);
        n_cmp++; if (alu_op !== 4'd5 || arg2 !== 32'h404) begin n_err++; $display("FAIL srai: got op %0d arg2 %h want 5/00000404", alu_op, arg2); end
        // addi x0,x0,1
        load(32'h8, 7'b0010011, 3'b000, 1'b0, 5'd0, 5'd1, 5'd0, 32'd0, 32'd0, 32'd1);
        @(negedge clk);
        n_cmp++; if (alu_op !== 4'd6 || ex_reg_wen !== 1'b0) begin n_err++; $display("FAIL addi_x0: got op %0d wen %b want 6/0", alu_op, ex_reg_wen); end
        // addi x7,x1,-1024: instr[30] set but still ADD
        load(32'hC, 7'b0010011, 3'b000, 1'b1, 5'd1, 5'd0, 5'd7, 32'd5, 32'd0, 32'hFFFFFC00);
        @(negedge clk);
        n_cmp++; if (alu_op !== 4'd6 || ex_reg_wen !== 1'b1) begin n_err++; $display("FAIL addi_neg: got op %0d wen %b want 6/1", alu_op, ex_reg_wen); end
        id_valid = 1'b0;
    endtask

    task automatic test_forwarding();
        load(32'h20, 7'b0110011, 3'b000, 1'b0, 5'd4, 5'd5, 5'd6, 32'd1, 32'd2, 32'd0);
        @(negedge clk);
        id_valid = 1'b0;
        exmem_wen = 1'b1; exmem_rd = 5'd4; exmem_result = 32'hAA;
        memwb_wen = 1'b1; memwb_rd = 5'd4; memwb_result = 32'hBB;
        #1;
        n_cmp++; if (arg1 !== (FWD ? 32'hAA : 32'd1)) begin n_err++; $display("FAIL fwd_exmem: got %h want %h", arg1, FWD ? 32'hAA : 32'd1); end
        n_cmp++; if (arg2 !== 32'd2) begin n_err++; $display("FAIL fwd_nohit: got %h want 2", arg2); end
        exmem_rd = 5'd0;
        #1;
        n_cmp++; if (arg1 !== (FWD ? 32'hBB : 32'd1)) begin n_err++; $display("FAIL fwd_memwb: got %h want %h", arg1, FWD ? 32'hBB : 32'd1); end
        exmem_rd = 5'd5; exmem_result = 32'hCC;
        #1;
        n_cmp++; if (ex_store_data !== (FWD ? 32'hCC : 32'd2)) begin n_err++; $display("FAIL fwd_store: got %h want %h", ex_store_data, FWD ? 32'hCC : 32'd2); end
        exmem_wen = 1'b0; memwb_wen = 1'b0;
        @(negedge clk);
        load(32'h24, 7'b0110011, 3'b000, 1'b0, 5'd0, 5'd0, 5'd7, 32'd0, 32'd0, 32'd0);
        @(negedge clk);
        id_valid = 1'b0;
        exmem_wen = 1'b1; exmem_rd = 5'd0; exmem_result = 32'hAA;
        memwb_wen = 1'b1; memwb_rd = 5'd0; memwb_result = 32'hBB;
        #1;
        n_cmp++; if (arg1 !== 32'd0) begin n_err++; $display("FAIL fwd_x0: got %h want 0", arg1); end
        exmem_wen = 1'b0; memwb_wen = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stall_flush();
        // add x8,x9,x10
        load(32'h40, 7'b0110011, 3'b000, 1'b0, 5'd9, 5'd10, 5'd8, 32'h11, 32'h22, 32'd0);
        @(negedge clk);
        ex_ready = 1'b0;
        load(32'h44, 7'b0110011, 3'b111, 1'b0, 5'd1, 5'd2, 5'd11, 32'h99, 32'h0F, 32'd0);
        memwb_wen = 1'b1; memwb_rd = 5'd10; memwb_result = 32'h55;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (ex_valid !== 1'b1 || id_ready !== 1'b0) begin n_err++; $display("FAIL stall_hs[%0d]: got valid %b ready %b want 1/0", i, ex_valid, id_ready); end
            n_cmp++; if (alu_op !== 4'd6 || arg1 !== 32'h11 || ex_pc !== 32'h40) begin n_err++; $display("FAIL stall_hold[%0d]: got op %0d arg1 %h pc %h want 6/11/40", i, alu_op, arg1, ex_pc); end
            n_cmp++; if (arg2 !== (FWD ? 32'h55 : 32'h22)) begin n_err++; $display("FAIL stall_arg2[%0d]: got %h want %h", i, arg2, FWD ? 32'h55 : 32'h22); end
        end
        memwb_wen = 1'b0;
        #1;
        n_cmp++; if (arg2 !== (FWD ? 32'h55 : 32'h22)) begin n_err++; $display("FAIL stall_refresh: got %h want %h", arg2, FWD ? 32'h55 : 32'h22); end
        flush = 1'b1;
        @(negedge clk);
        n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL flush_stalled: got %b want 0", ex_valid); end
        // capture attempt while flushing must stay killed
        @(negedge clk);
        n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL flush_capture: got %b want 0", ex_valid); end
        flush = 1'b0; ex_ready = 1'b1;
        @(negedge clk);
        id_valid = 1'b0;
        n_cmp++; if (ex_valid !== 1'b1 || alu_op !== 4'd0 || arg1 !== 32'h99) begin n_err++; $display("FAIL post_flush: got valid %b op %0d arg1 %h want 1/0/99", ex_valid, alu_op, arg1); end
    endtask

    task automatic test_back_to_back();
        // jal x1 at 0x100
        load(32'h100, 7'b1101111, 3'b000, 1'b0, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'h20);
        @(negedge clk);
        n_cmp++; if (alu_op !== 4'd6 || arg1 !== 32'h100 || arg2 !== 32'd4 || ex_reg_wen !== 1'b1) begin n_err++; $display("FAIL jal: got op %0d arg1 %h arg2 %h wen %b want 6/100/4/1", alu_op, arg1, arg2, ex_reg_wen); end
        // lui x2,0x12345
        load(32'h104, 7'b0110111, 3'b101, 1'b0, 5'd5, 5'd0, 5'd2, 32'hDEAD, 32'd0, 32'h12345000);
        @(negedge clk);
        n_cmp++; if (arg1 !== 32'd0 || arg2 !== 32'h12345000) begin n_err++; $display("FAIL lui: got %h/%h want 0/12345000", arg1, arg2); end
        // auipc x3,0x1
        load(32'h200, 7'b0010111, 3'b000, 1'b0, 5'd0, 5'd0, 5'd3, 32'd0, 32'd0, 32'h1000);
        @(negedge clk);
        n_cmp++; if (arg1 !== 32'h200 || arg2 !== 32'h1000) begin n_err++; $display("FAIL auipc: got %h/%h want 200/1000", arg1, arg2); end
        // bltu x4,x5
        load(32'h204, 7'b1100011, 3'b110, 1'b0, 5'd4, 5'd5, 5'd12, 32'd7, 32'd9, 32'h10);
        @(negedge clk);
        n_cmp++; if (alu_op !== 4'd9 || arg2 !== 32'd9 || ex_reg_wen !== 1'b0) begin n_err++; $display("FAIL bltu: got op %0d arg2 %h wen %b want 9/9/0", alu_op, arg2, ex_reg_wen); end
        // sw x6,8(x7)
        load(32'h208, 7'b0100011, 3'b010, 1'b0, 5'd7, 5'd6, 5'd8, 32'h1000, 32'h77, 32'd8);
        @(negedge clk);
        n_cmp++; if (alu_op !== 4'd6 || arg2 !== 32'd8 || ex_store_data !== 32'h77 || ex_reg_wen !== 1'b0) begin n_err++; $display("FAIL store: got op %0d arg2 %h sd %h wen %b want 6/8/77/0", alu_op, arg2, ex_store_data, ex_reg_wen); end
        // or, then xor immediately behind it
        load(32'h20C, 7'b0110011, 3'b110, 1'b0, 5'd12, 5'd13, 5'd11, 32'hF0, 32'h0F, 32'd0);
        @(negedge clk);
        n_cmp++; if (alu_op !== 4'd1 || ex_pc !== 32'h20C) begin n_err++; $display("FAIL b2b_or: got op %0d pc %h want 1/20c", alu_op, ex_pc); end
        load(32'h210, 7'b0110011, 3'b100, 1'b0, 5'd14, 5'd15, 5'd16, 32'h3, 32'h5, 32'd0);
        @(negedge clk);
        n_cmp++; if (alu_op !== 4'd2 || arg1 !== 32'h3 || ex_illegal !== 1'b0) begin n_err++; $display("FAIL b2b_xor: got op %0d arg1 %h ill %b want 2/3/0", alu_op, arg1, ex_illegal); end
        // illegal opcode
        load(32'h214, 7'h7F, 3'b000, 1'b0, 5'd1, 5'd2, 5'd5, 32'd0, 32'd0, 32'd0);
        @(negedge clk);
        id_valid = 1'b0;
        n_cmp++; if (ex_illegal !== 1'b1 || ex_reg_wen !== 1'b0 || alu_op !== 4'd6) begin n_err++; $display("FAIL illegal: got ill %b wen %b op %0d want 1/0/6", ex_illegal, ex_reg_wen, alu_op); end
    endtask

    initial begin
        test_reset();
        test_alu_decode();
        test_forwarding();
        test_stall_flush();
        test_back_to_back();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
